// File: rtl/vga_ram_arbiter.sv
// Single-port image RAM arbiter: real-time video reads take strict priority over a
// best-effort filter port, with a tag pipeline steering returned read data to its owner.
module vga_ram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              flt_req,
    input  logic              flt_we,
    input  logic [ADDR_W-1:0] flt_addr,
    input  logic [DATA_W-1:0] flt_wdata,
    output logic              flt_gnt,
    output logic [DATA_W-1:0] flt_rdata,
    output logic              flt_rvalid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam int IS_VID = 1;
    localparam int IS_FLT = 0;

    // One {is_vid, is_flt_rd} tag per edge of RAM latency; stage RD_LAT lines up with ram_q.
    logic [RD_LAT:0][1:0] tag;
    logic [1:0]           tag_in;

    // Video never stalls, so the filter only sees a grant in cycles video leaves free.
    always_comb begin
        flt_gnt   = flt_req & ~vid_req & ~rst;
        ram_addr  = vid_req ? vid_addr : flt_addr;
        ram_wdata = flt_wdata;
        ram_we    = flt_gnt & flt_we;
        tag_in    = {vid_req, flt_gnt & ~flt_we};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag          <= '0;
            vid_valid    <= 1'b0;
            flt_rvalid   <= 1'b0;
            vid_data     <= '0;
            flt_rdata    <= '0;
            conflict_cnt <= '0;
        end else begin
            tag        <= {tag[RD_LAT-1:0], tag_in};
            vid_valid  <= tag[RD_LAT][IS_VID];
            flt_rvalid <= tag[RD_LAT][IS_FLT];
            if (tag[RD_LAT][IS_VID]) begin
                vid_data <= ram_q;
            end
            if (tag[RD_LAT][IS_FLT]) begin
                flt_rdata <= ram_q;
            end
            // Saturating: a long stall must not wrap back to a small, misleading count.
            if (flt_req && vid_req && !(&conflict_cnt)) begin
                conflict_cnt <= conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_vga_ram_arbiter.sv
// Randomized scoreboard bench for vga_ram_arbiter: a reference memory predicts read data,
// a negedge monitor pops expected returns and checks the combinational arbitration outputs.
module tb_vga_ram_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_data;
    logic              vid_valid;
    logic              flt_req;
    logic              flt_we;
    logic [ADDR_W-1:0] flt_addr;
    logic [DATA_W-1:0] flt_wdata;
    logic              flt_gnt;
    logic [DATA_W-1:0] flt_rdata;
    logic              flt_rvalid;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_q;
    logic [15:0]       conflict_cnt;

    logic [DATA_W-1:0] s_vid_data, s_flt_rdata, s_ram_wdata;
    logic              s_vid_valid, s_flt_gnt, s_flt_rvalid, s_ram_we;
    logic [ADDR_W-1:0] s_ram_addr;
    logic [3:0]        s_conflict_cnt;

    vga_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
        .flt_req(flt_req), .flt_we(flt_we), .flt_addr(flt_addr), .flt_wdata(flt_wdata),
        .flt_gnt(flt_gnt), .flt_rdata(flt_rdata), .flt_rvalid(flt_rvalid),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_q(ram_q),
        .conflict_cnt(conflict_cnt)
    );

    // Narrow-counter copy, used only to observe saturation.
    vga_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(s_vid_data), .vid_valid(s_vid_valid),
        .flt_req(flt_req), .flt_we(flt_we), .flt_addr(flt_addr), .flt_wdata(flt_wdata),
        .flt_gnt(s_flt_gnt), .flt_rdata(s_flt_rdata), .flt_rvalid(s_flt_rvalid),
        .ram_addr(s_ram_addr), .ram_wdata(s_ram_wdata), .ram_we(s_ram_we), .ram_q(ram_q),
        .conflict_cnt(s_conflict_cnt)
    );

    always #10 clk = ~clk;

    // RAM stand-in: address sampled on edge E, ram_q valid after edge E+RD_LAT.
    logic [DATA_W-1:0] mem [256];
    logic [DATA_W-1:0] rpipe [RD_LAT+1];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
        rpipe[0] <= mem[ram_addr[7:0]];
        for (int k = 1; k <= RD_LAT; k++) rpipe[k] <= rpipe[k-1];
    end
    assign ram_q = rpipe[RD_LAT];

    typedef struct {
        logic [DATA_W-1:0] data;
        int                issue;
    } ret_t;

    ret_t              vid_q[$];
    ret_t              flt_q[$];
    logic [DATA_W-1:0] shadow [256];
    logic [DATA_W-1:0] exp_vid_data, exp_flt_data;
    int                exp_cnt16, exp_cnt4;
    int                edge_cnt = 0;
    bit                started = 0;
    int                vectors = 0;
    int                miscompares = 0;
    int                grant_cnt = 0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Reference model: video always wins the port; a filter op happens only in a free cycle.
    always @(posedge clk) begin
        ret_t item;
        edge_cnt++;
        started = 1;
        if (rst) begin
            vid_q.delete();
            flt_q.delete();
            exp_vid_data = '0;
            exp_flt_data = '0;
            exp_cnt16    = 0;
            exp_cnt4     = 0;
        end else begin
            if (vid_req) begin
                item.data  = shadow[vid_addr[7:0]];
                item.issue = edge_cnt;
                vid_q.push_back(item);
            end else if (flt_req) begin
                if (flt_we) begin
                    shadow[flt_addr[7:0]] = flt_wdata;
                end else begin
                    item.data  = shadow[flt_addr[7:0]];
                    item.issue = edge_cnt;
                    flt_q.push_back(item);
                end
            end
            if (flt_req && vid_req) begin
                if (exp_cnt16 < 65535) exp_cnt16++;
                if (exp_cnt4 < 15) exp_cnt4++;
            end
        end
    end

    // Monitor: samples away from the active edge and retires expected returns in order.
    always @(negedge clk) begin
        ret_t item;
        if (started) begin
            check_output("flt_gnt", flt_gnt, flt_req & ~vid_req & ~rst);
            check_output("ram_addr", ram_addr, vid_req ? vid_addr : flt_addr);
            check_output("ram_we", ram_we, flt_req & ~vid_req & ~rst & flt_we);
            if (ram_we) check_output("ram_wdata", ram_wdata, flt_wdata);
            check_output("conflict_cnt", conflict_cnt, exp_cnt16[15:0]);
            check_output("conflict_cnt_sat", s_conflict_cnt, exp_cnt4[3:0]);
            check_output("coincident_valid", vid_valid & flt_rvalid, 0);
            if (flt_gnt) grant_cnt++;

            if (vid_valid) begin
                if (vid_q.size() == 0) begin
                    check_output("vid_spurious", vid_valid, 0);
                end else begin
                    item = vid_q.pop_front();
                    exp_vid_data = item.data;
                    check_output("vid_latency", edge_cnt - item.issue, RD_LAT + 1);
                end
            end else if (vid_q.size() != 0 && edge_cnt - vid_q[0].issue > RD_LAT + 1) begin
                check_output("vid_missing", vid_valid, 1);
                void'(vid_q.pop_front());
            end
            check_output("vid_data", vid_data, exp_vid_data);

            if (flt_rvalid) begin
                if (flt_q.size() == 0) begin
                    check_output("flt_spurious", flt_rvalid, 0);
                end else begin
                    item = flt_q.pop_front();
                    exp_flt_data = item.data;
                    check_output("flt_latency", edge_cnt - item.issue, RD_LAT + 1);
                end
            end else if (flt_q.size() != 0 && edge_cnt - flt_q[0].issue > RD_LAT + 1) begin
                check_output("flt_missing", flt_rvalid, 1);
                void'(flt_q.pop_front());
            end
            check_output("flt_rdata", flt_rdata, exp_flt_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic v, input logic [ADDR_W-1:0] va,
                                  input logic f, input logic w,
                                  input logic [ADDR_W-1:0] fa, input logic [DATA_W-1:0] wd);
        vid_req   = v;
        vid_addr  = va;
        flt_req   = f;
        flt_we    = w;
        flt_addr  = fa;
        flt_wdata = wd;
        tick();
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        logic              granted;

        rst = 1'b1;
        vid_req = 1'b0; vid_addr = '0;
        flt_req = 1'b0; flt_we = 1'b0; flt_addr = '0; flt_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 8'($urandom_range(0, 255));
            shadow[i] = mem[i];
        end
        mem[16] = 8'hA5;
        shadow[16] = 8'hA5;
        for (int k = 0; k <= RD_LAT; k++) rpipe[k] = '0;

        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single video read of the preloaded pixel.
        apply_stimulus(1, 32'h10, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        repeat (5) tick();

        // Filter write then read-back of the same address.
        apply_stimulus(0, 0, 1, 1, 32'h20, 8'h3C);
        apply_stimulus(0, 0, 1, 0, 32'h20, 8'h00);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        repeat (5) tick();

        // Same-cycle conflict, then video reading a just-written address.
        apply_stimulus(1, 32'h10, 1, 0, 32'h30, 0);
        apply_stimulus(0, 0, 1, 0, 32'h30, 0);
        apply_stimulus(0, 0, 1, 1, 32'h31, 8'h77);
        apply_stimulus(1, 32'h31, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        repeat (5) tick();

        // Streaming: video every other cycle, filter reads held until granted.
        grant_cnt = 0;
        a = 32'h40;
        for (int i = 0; i < 100; i++) begin
            apply_stimulus(i % 2 == 0, 32'($urandom_range(0, 63)), 1, 0, a, 0);
            if (i % 2 != 0) a = a + 1;
        end
        flt_req = 1'b0;
        vid_req = 1'b0;
        check_output("stream_grants", grant_cnt, 50);
        repeat (6) tick();

        // Reset with reads in flight: neither may ever return.
        apply_stimulus(1, 32'h05, 0, 0, 0, 0);
        apply_stimulus(0, 0, 1, 0, 32'h06, 0);
        flt_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (6) tick();

        // Twenty back-to-back conflicts push the 4-bit counter into saturation.
        for (int i = 0; i < 20; i++) apply_stimulus(1, 32'(i), 1, 0, 32'h50, 0);
        apply_stimulus(0, 0, 1, 0, 32'h50, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("sat_final", s_conflict_cnt, 4'hF);
        repeat (6) tick();

        // Random traffic obeying the video spacing and filter hold rules.
        for (int i = 0; i < 400; i++) begin
            granted = flt_req && !vid_req;
            if (!flt_req || granted) begin
                flt_req   = ($urandom_range(0, 2) != 0);
                flt_we    = 1'($urandom_range(0, 1));
                flt_addr  = 32'($urandom_range(0, 63));
                flt_wdata = 8'($urandom_range(0, 255));
            end
            vid_req  = !vid_req && ($urandom_range(0, 1) == 1);
            vid_addr = 32'($urandom_range(0, 63));
            tick();
        end
        vid_req = 1'b0;
        flt_req = 1'b0;
        repeat (8) tick();

        check_output("vid_q_drained", vid_q.size(), 0);
        check_output("flt_q_drained", flt_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
